// File: rtl/seq_divider.sv
// seq_divider: multi-cycle signed restoring divider for the EX stage.
// One quotient bit per clock. The result is packed as {remainder, quotient}
// so the HI/LO write path can treat it exactly like a multiply result.
// The quotient truncates toward zero and the remainder takes the dividend's
// sign. A zero divisor keeps the same latency, forces an all-ones quotient,
// and returns the original dividend as the remainder.
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               ready,
    output logic [2*WIDTH-1:0] result,
    output logic               div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   rem_q;       // partial remainder (always < |b| when b != 0)
    logic [WIDTH-1:0]   dvd_q;       // dividend magnitude shifting out, quotient bits shifting in
    logic [WIDTH:0]     dsr_q;       // divisor magnitude, one extra bit so |-2^(W-1)| is exact
    logic [WIDTH-1:0]   a_q;         // original dividend, returned as remainder on divide by zero
    logic [CW-1:0]      cnt_q;
    logic               sign_quo_q;
    logic               sign_rem_q;
    logic               ready_q;
    logic [2*WIDTH-1:0] result_q;
    logic               dbz_q;

    // Magnitudes of the incoming operands. For the dividend a WIDTH-bit
    // unsigned value is enough: negating -2^(W-1) gives 2^(W-1) exactly.
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH:0]     abs_b;

    // One restoring-division step from the current registers.
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH-1:0]   diff;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_d;
    logic [WIDTH-1:0]   dvd_d;

    // Final sign correction applied in FIX.
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Operand magnitudes, the iteration datapath, and sign fix-up.
    always_comb begin
        abs_a     = a[WIDTH-1] ? (~a + 1'b1) : a;
        abs_b     = {1'b0, (b[WIDTH-1] ? (~b + 1'b1) : b)};

        rem_shift = {rem_q, dvd_q[WIDTH-1]};
        q_bit     = (rem_shift >= dsr_q);
        // When the subtraction succeeds the difference is below |b|, so the
        // low WIDTH bits hold it exactly.
        diff      = rem_shift[WIDTH-1:0] - dsr_q[WIDTH-1:0];
        rem_d     = q_bit ? diff : rem_shift[WIDTH-1:0];
        dvd_d     = {dvd_q[WIDTH-2:0], q_bit};

        quo_fix   = sign_quo_q ? (~dvd_q + 1'b1) : dvd_q;
        rem_fix   = sign_rem_q ? (~rem_q + 1'b1) : rem_q;
        if (dbz_q) begin
            quo_fix = '1;
            rem_fix = a_q;
        end
    end

    // Control FSM with registered outputs; reset has priority over start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            dvd_q      <= '0;
            dsr_q      <= '0;
            a_q        <= '0;
            cnt_q      <= '0;
            sign_quo_q <= 1'b0;
            sign_rem_q <= 1'b0;
            ready_q    <= 1'b0;
            result_q   <= '0;
            dbz_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (start) begin
                        sign_quo_q <= a[WIDTH-1] ^ b[WIDTH-1];
                        sign_rem_q <= a[WIDTH-1];
                        dbz_q      <= (b == '0);
                        a_q        <= a;
                        dvd_q      <= abs_a;
                        dsr_q      <= abs_b;
                        rem_q      <= '0;
                        cnt_q      <= '0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    if (!start) begin
                        state_q <= IDLE;
                        ready_q <= 1'b0;
                    end else begin
                        rem_q <= rem_d;
                        dvd_q <= dvd_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            state_q <= FIX;
                        end
                    end
                end
                FIX: begin
                    if (!start) begin
                        state_q <= IDLE;
                        ready_q <= 1'b0;
                    end else begin
                        result_q <= {rem_fix, quo_fix};
                        ready_q  <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    // Holding start high here never re-triggers; a drop is required.
                    if (!start) begin
                        state_q <= IDLE;
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready       = ready_q;
    assign result      = result_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vectors with hand-computed results. Stimulus pushes
// the expected {result, div_by_zero} into a queue; a monitor pops and compares
// on each rising edge of ready.
module tb_seq_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        ready;
    logic [31:0] result;
    logic        div_by_zero;

    typedef struct packed {
        logic [31:0] res;
        logic        dbz;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_txn = 0;
    logic ready_prev = 1'b0;

    seq_divider #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .ready       (ready),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare each new result against the oldest expectation.
    always @(negedge clk) begin
        if (ready && !ready_prev) begin
            n_txn++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_ready: got result=%h dbz=%b, required no result", result, div_by_zero);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("txn %0d: result=%h dbz=%b expected=%h/%b", n_txn, result, div_by_zero, e.res, e.dbz);
                n_cmp++;
                if (result !== e.res) begin
                    n_err++;
                    $display("FAIL result: got %h, required %h", result, e.res);
                end
                n_cmp++;
                if (div_by_zero !== e.dbz) begin
                    n_err++;
                    $display("FAIL div_by_zero: got %b, required %b", div_by_zero, e.dbz);
                end
            end
        end
        ready_prev = ready;
    end

    // Wait for ready (bounded) and check the edge count from the load edge.
    task automatic wait_ready(input string name, input bit scramble);
        int  n;
        bit  got;
        n   = 0;
        got = 0;
        while (!got && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (ready) got = 1;
            else if (scramble) begin
                a = 16'($urandom);
                b = 16'($urandom);
            end
        end
        n_cmp++;
        if (!got || n != 18) begin
            n_err++;
            $display("FAIL %s_latency: got %0d edges (ready=%b), required 18", name, n, got);
        end
    endtask

    // Full operation: issue, wait, hold start for some cycles, then release.
    task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                          input logic [31:0] er, input logic edz,
                          input string name, input int hold, input bit scramble);
        exp_q.push_back('{res: er, dbz: edz});
        a     = av;
        b     = bv;
        start = 1'b1;
        wait_ready(name, scramble);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (ready !== 1'b1 || result !== er) begin
                n_err++;
                $display("FAIL %s_hold%0d: got ready=%b result=%h, required ready=1 result=%h", name, i, ready, result, er);
            end
        end
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (ready !== 1'b0 || result !== er) begin
            n_err++;
            $display("FAIL %s_release: got ready=%b result=%h, required ready=0 result=%h", name, ready, result, er);
        end
    endtask

    initial begin
        bit saw_ready;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (ready !== 1'b0 || result !== 32'h0 || div_by_zero !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got ready=%b result=%h dbz=%b, required 0/00000000/0", ready, result, div_by_zero);
        end

        run_op(16'd100,  16'd7,  32'h0002_000E, 1'b0, "p_div_p", 5, 0);
        run_op(-16'sd100, 16'd7, 32'hFFFE_FFF2, 1'b0, "n_div_p", 1, 0);
        run_op(16'd100, -16'sd7, 32'h0002_FFF2, 1'b0, "p_div_n", 1, 0);
        run_op(-16'sd100, -16'sd7, 32'hFFFE_000E, 1'b0, "n_div_n", 1, 0);
        run_op(16'd7,    16'd0,  32'h0007_FFFF, 1'b1, "div_zero", 1, 0);
        run_op(-16'sd7,  16'd0,  32'hFFF9_FFFF, 1'b1, "neg_div_zero", 0, 0);
        run_op(16'h8000, 16'hFFFF, 32'h0000_8000, 1'b0, "overflow", 1, 0);

        // Abort: drop start after edge 6 of 1000/3.
        a     = 16'd1000;
        b     = 16'd3;
        start = 1'b1;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
        end
        start     = 1'b0;
        saw_ready = 0;
        repeat (30) begin
            @(posedge clk);
            @(negedge clk);
            if (ready) saw_ready = 1;
        end
        n_cmp++;
        if (saw_ready || result !== 32'h0000_8000) begin
            n_err++;
            $display("FAIL abort: got ready_seen=%b result=%h, required 0 and 00008000", saw_ready, result);
        end
        run_op(16'd50, 16'd5, 32'h0000_000A, 1'b0, "after_abort", 0, 0);

        // Reset mid-RUN with start still high, then a fresh operation.
        a     = 16'd1000;
        b     = 16'd3;
        start = 1'b1;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (ready !== 1'b0 || result !== 32'h0 || div_by_zero !== 1'b0) begin
            n_err++;
            $display("FAIL midrun_reset: got ready=%b result=%h dbz=%b, required 0/00000000/0", ready, result, div_by_zero);
        end
        rst = 1'b0;
        exp_q.push_back('{res: 32'h0002_FF90, dbz: 1'b0});
        a = 16'd1234;
        b = -16'sd11;
        wait_ready("after_reset", 0);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Operands scrambled every cycle after the load edge.
        run_op(16'd30000, -16'sd123, 32'h006F_FF0D, 1'b0, "scramble", 0, 1);
        run_op(16'd0, 16'd5, 32'h0000_0000, 1'b0, "zero_dividend", 0, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pending_results: got %0d unconsumed, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
